// File: rtl/viterbi_dec_ctrl.sv
// Frame sequencer for the radix-4 Viterbi decoder: symbol handshake, BMU/ACS
// strobe timing, survivor RAM write addressing and traceback launch.
module viterbi_dec_ctrl #(
  parameter int TB_DEPTH = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_sym_valid,
  input  logic              i_last_sym,
  input  logic              i_tb_done,
  output logic              o_sym_ready,
  output logic              o_en_dist,
  output logic              o_en_acs,
  output logic              o_acs_clr,
  output logic              o_sv_wr_en,
  output logic [ADDR_W-1:0] o_sv_wr_addr,
  output logic              o_tb_start,
  output logic [ADDR_W-1:0] o_tb_addr,
  output logic [ADDR_W:0]   o_tb_len,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_TRACE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(TB_DEPTH);

  logic [2:0]        state_q,     state_d;
  logic [ADDR_W:0]   sym_cnt_q,   sym_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic              sym_ready_q, sym_ready_d;
  logic              en_dist_q,   en_dist_d;
  logic              en_acs_q,    en_acs_d;
  logic              acs_clr_q,   acs_clr_d;
  logic [ADDR_W-1:0] sv_addr_q,   sv_addr_d;
  logic              tb_start_q,  tb_start_d;
  logic [ADDR_W-1:0] tb_addr_q,   tb_addr_d;
  logic [ADDR_W:0]   tb_len_q,    tb_len_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              accept;

  assign accept = i_sym_valid & sym_ready_q & (state_q == S_RUN);

  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    wr_addr_d   = wr_addr_q;
    sym_ready_d = 1'b0;
    en_dist_d   = 1'b0;
    en_acs_d    = en_dist_q;
    acs_clr_d   = 1'b0;
    sv_addr_d   = sv_addr_q;
    tb_start_d  = 1'b0;
    tb_addr_d   = tb_addr_q;
    tb_len_d    = tb_len_q;
    done_d      = 1'b0;

    // Write address is latched as the ACS strobe is issued, so back-to-back
    // symbols each see their own column.
    if (en_dist_q) begin
      sv_addr_d = wr_addr_q;
      wr_addr_d = wr_addr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          acs_clr_d   = 1'b1;
          sym_cnt_d   = '0;
          wr_addr_d   = '0;
          sym_ready_d = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        sym_ready_d = 1'b1;
        if (accept) begin
          en_dist_d = 1'b1;
          if (sym_cnt_q != CNT_MAX) sym_cnt_d = sym_cnt_q + 1'b1;
          if (i_last_sym) begin
            sym_ready_d = 1'b0;
            state_d     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Final write is in flight when en_acs is high with nothing behind it.
        if (en_acs_q && !en_dist_q) begin
          tb_start_d = 1'b1;
          tb_addr_d  = sv_addr_q;
          tb_len_d   = sym_cnt_q;
          state_d    = S_TRACE;
        end
      end
      S_TRACE: begin
        if (i_tb_done) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (i_abort) begin
      state_d     = S_IDLE;
      sym_ready_d = 1'b0;
      en_dist_d   = 1'b0;
      en_acs_d    = 1'b0;
      acs_clr_d   = 1'b0;
      tb_start_d  = 1'b0;
      done_d      = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sym_cnt_q   <= '0;
      wr_addr_q   <= '0;
      sym_ready_q <= 1'b0;
      en_dist_q   <= 1'b0;
      en_acs_q    <= 1'b0;
      acs_clr_q   <= 1'b0;
      sv_addr_q   <= '0;
      tb_start_q  <= 1'b0;
      tb_addr_q   <= '0;
      tb_len_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      wr_addr_q   <= wr_addr_d;
      sym_ready_q <= sym_ready_d;
      en_dist_q   <= en_dist_d;
      en_acs_q    <= en_acs_d;
      acs_clr_q   <= acs_clr_d;
      sv_addr_q   <= sv_addr_d;
      tb_start_q  <= tb_start_d;
      tb_addr_q   <= tb_addr_d;
      tb_len_q    <= tb_len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_sym_ready  = sym_ready_q;
  assign o_en_dist    = en_dist_q;
  assign o_en_acs     = en_acs_q;
  assign o_sv_wr_en   = en_acs_q;
  assign o_acs_clr    = acs_clr_q;
  assign o_sv_wr_addr = sv_addr_q;
  assign o_tb_start   = tb_start_q;
  assign o_tb_addr    = tb_addr_q;
  assign o_tb_len     = tb_len_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule
